// File: rtl/coffee_pkg.sv
// coffee_pkg: shared state encoding, price table and coin values for the coffee machine front end.
package coffee_pkg;
    typedef enum logic [1:0] {COLLECT, VEND, DONE} credit_state_t;
    localparam logic [3:0] PRICE [4] = '{4'd3, 4'd5, 4'd6, 4'd8};
    localparam logic [4:0] COIN_SMALL = 5'd1;
    localparam logic [4:0] COIN_LARGE = 5'd5;
endpackage

// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronises a raw button, debounces it and emits one pulse per debounced press.
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s1, s2, level_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            level <= 1'b0;
            level_q <= 1'b0;
            pulse <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            level_q <= level;
            pulse <= level & ~level_q;
            // cnt holds how many consecutive samples so far disagreed with the accepted level
            if (s2 == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= s2;
                cnt <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/coin_credit_unit.sv
// coin_credit_unit: debounced coin/start inputs, credit accumulation, price check, change and dispense handshake.
module coin_credit_unit
    import coffee_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CREDIT_MAX = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_100_raw,
    input  logic       coin_500_raw,
    input  logic       start_raw,
    input  logic [1:0] coffee_type,
    input  logic       dispense_ack,
    output logic [3:0] credit,
    output logic [3:0] change,
    output logic       dispense_req,
    output logic [1:0] dispense_type,
    output logic       coin_reject,
    output logic       insufficient
);
    credit_state_t state;
    logic c100, c500, start_p, accept;
    logic [4:0] coin_val, sum;
    logic [3:0] credit_new, price;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_c100 (
        .clock(clock), .reset(reset), .raw(coin_100_raw), .level(), .pulse(c100));
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_c500 (
        .clock(clock), .reset(reset), .raw(coin_500_raw), .level(), .pulse(c500));
    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clock(clock), .reset(reset), .raw(start_raw), .level(), .pulse(start_p));

    // The large coin wins a same-cycle tie; the small one is then reported as refused.
    always_comb begin
        coin_val = c500 ? COIN_LARGE : c100 ? COIN_SMALL : 5'd0;
        sum = {1'b0, credit} + coin_val;
        accept = (c500 | c100) && (sum <= 5'(CREDIT_MAX));
        credit_new = accept ? sum[3:0] : credit;
        price = PRICE[coffee_type];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= COLLECT;
            credit <= '0;
            change <= '0;
            dispense_req <= 1'b0;
            dispense_type <= '0;
            coin_reject <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            insufficient <= 1'b0;
            case (state)
                COLLECT: begin
                    credit <= credit_new;
                    if (accept)
                        change <= '0;
                    coin_reject <= (c100 & c500) | ((c100 | c500) & ~accept);
                    if (start_p) begin
                        if (credit_new >= price) begin
                            change <= credit_new - price;
                            dispense_type <= coffee_type;
                            dispense_req <= 1'b1;
                            state <= VEND;
                        end else
                            insufficient <= 1'b1;
                    end
                end
                VEND: begin
                    coin_reject <= c100 | c500;
                    if (dispense_ack) begin
                        dispense_req <= 1'b0;
                        credit <= '0;
                        state <= DONE;
                    end
                end
                default: begin
                    coin_reject <= c100 | c500;
                    state <= COLLECT;
                end
            endcase
        end
    end
endmodule
